// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_if
// Brief  : EX/MEM inputs and MEM/WB outputs of the MIPS memory-access stage
// Rev    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
  logic [31:0] res;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register;
  logic        zero;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        pcsrc;
  logic [1:0]  wb_WB;
  logic [4:0]  write_register_wb;
  logic [31:0] alu_res_wb;
  logic [31:0] read_data_wb;
  logic [31:0] write_data_wb;
  logic        mem_fault;
  logic [31:0] fault_addr;

  modport master (
    output res, write_data_ex, write_register, zero, m_MEM, wb_MEM,
    input  pcsrc, wb_WB, write_register_wb, alu_res_wb, read_data_wb,
           write_data_wb, mem_fault, fault_addr
  );

  modport slave (
    input  res, write_data_ex, write_register, zero, m_MEM, wb_MEM,
    output pcsrc, wb_WB, write_register_wb, alu_res_wb, read_data_wb,
           write_data_wb, mem_fault, fault_addr
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Brief  : MIPS MEM stage: data memory, branch resolve, MEM/WB register, faults
// Rev    : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_stage_if.slave  bus
);

  logic [31:0]       r_mem [DEPTH];
  logic              w_branch;
  logic              w_read;
  logic              w_write;
  logic [ADDR_W-1:0] w_idx;
  logic              w_legal;
  logic              w_fault;
  logic              w_we;
  logic [31:0]       w_rdata;

  assign w_branch = bus.m_MEM[2];
  assign w_read   = bus.m_MEM[1];
  assign w_write  = bus.m_MEM[0];
  assign w_idx    = bus.res[ADDR_W+1:2];
  assign w_legal  = (bus.res[1:0] == 2'b00) && (bus.res[31:ADDR_W+2] == '0);
  assign w_fault  = (w_read | w_write) & ~w_legal;
  // Stores are blocked while reset is held so an in-flight store is dropped.
  assign w_we     = w_write & w_legal & ~rst;
  assign w_rdata  = r_mem[w_idx];

  assign bus.pcsrc         = w_branch & bus.zero;
  assign bus.write_data_wb = bus.wb_WB[1] ? bus.read_data_wb : bus.alu_res_wb;

  // Data array: not reset; read side sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= bus.write_data_ex;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_WB             <= 2'b00;
      bus.write_register_wb <= 5'd0;
      bus.alu_res_wb        <= 32'd0;
      bus.read_data_wb      <= 32'd0;
      bus.mem_fault         <= 1'b0;
      bus.fault_addr        <= 32'd0;
    end else begin
      bus.wb_WB             <= {bus.wb_MEM[1], bus.wb_MEM[0] & ~(w_read & w_fault)};
      bus.write_register_wb <= bus.write_register;
      bus.alu_res_wb        <= bus.res;
      bus.read_data_wb      <= (w_read & w_legal) ? w_rdata : 32'd0;
      if (w_fault) begin
        bus.mem_fault <= 1'b1;
        if (!bus.mem_fault) begin
          bus.fault_addr <= bus.res;
        end
      end
    end
  end

endmodule
`default_nettype wire
